// File: rtl/rx_frame_parser.sv
// rx_frame_parser: byte-level frame parser behind the UART receiver.
// Recognises SYNC, CMD, LEN, payload[LEN], CHK frames, streams the payload
// bytes and reports completion or abort with one-cycle pulses.
// CHK is the XOR of CMD, LEN and every payload byte; SYNC is excluded.
// Optional build macro RX_FRAME_STATS_EN adds saturating ok/error frame counters.
`timescale 1ns/1ps

module rx_frame_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         TO_W        = 17
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  cmd_o,
  output logic [7:0]  len_o,
  output logic [7:0]  pl_data_o,
  output logic        pl_valid_o,
  output logic [7:0]  pl_idx_o,
  output logic        frame_ok_o,
  output logic        frame_err_o,
  output logic [1:0]  err_code_o,
`ifdef RX_FRAME_STATS_EN
  output logic [15:0] ok_cnt_o,
  output logic [15:0] err_cnt_o,
`endif
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam logic [1:0]      ERR_CHK   = 2'd1;
  localparam logic [1:0]      ERR_LEN   = 2'd2;
  localparam logic [1:0]      ERR_TO    = 2'd3;
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ZERO   = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

  // Running frame checksum: fold one byte into the XOR accumulator.
  function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t          state_q;
  logic [7:0]      cmd_q;
  logic [7:0]      len_q;
  logic [7:0]      pl_data_q;
  logic            pl_valid_q;
  logic [7:0]      pl_idx_q;
  logic            frame_ok_q;
  logic            frame_err_q;
  logic [1:0]      err_code_q;
  logic            busy_q;
  logic [7:0]      chk_q;
  logic [7:0]      cnt_q;
  logic [TO_W-1:0] to_q;

  // Frame FSM: byte handling, inter-byte timeout and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      len_q       <= 8'h00;
      pl_data_q   <= 8'h00;
      pl_valid_q  <= 1'b0;
      pl_idx_q    <= 8'h00;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      busy_q      <= 1'b0;
      chk_q       <= 8'h00;
      cnt_q       <= 8'h00;
      to_q        <= TO_ZERO;
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle.
      pl_valid_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        to_q <= TO_ZERO;
        // Anything other than SYNC is line noise and is dropped silently.
        if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
          state_q <= ST_CMD;
          busy_q  <= 1'b1;
          chk_q   <= 8'h00;
          cnt_q   <= 8'h00;
        end
      end else if (!rx_valid_i) begin
        // Open frame with no byte this cycle: run the inter-byte timeout.
        if (to_q == TO_LAST) begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          frame_err_q <= 1'b1;
          err_code_q  <= ERR_TO;
          to_q        <= TO_ZERO;
        end else begin
          to_q <= to_q + TO_ONE;
        end
      end else begin
        // A byte arrived: it always wins over a timeout expiring now.
        to_q <= TO_ZERO;
        case (state_q)
          ST_CMD: begin
            cmd_q   <= rx_data_i;
            chk_q   <= rx_data_i;
            state_q <= ST_LEN;
          end
          ST_LEN: begin
            len_q <= rx_data_i;
            chk_q <= chk_upd(chk_q, rx_data_i);
            if (rx_data_i > MAX_LEN_B) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
            end else if (rx_data_i == 8'h00) begin
              state_q <= ST_CHK;
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            pl_data_q  <= rx_data_i;
            pl_idx_q   <= cnt_q;
            pl_valid_q <= 1'b1;
            chk_q      <= chk_upd(chk_q, rx_data_i);
            cnt_q      <= cnt_q + 8'd1;
            // len_q is at least 1 here, so len_q-1 cannot wrap.
            if (cnt_q == (len_q - 8'd1)) begin
              state_q <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (rx_data_i == chk_q) begin
              frame_ok_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHK;
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_o       = cmd_q;
  assign len_o       = len_q;
  assign pl_data_o   = pl_data_q;
  assign pl_valid_o  = pl_valid_q;
  assign pl_idx_o    = pl_idx_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = busy_q;

`ifdef RX_FRAME_STATS_EN
  logic [15:0] ok_cnt_q;
  logic [15:0] ok_cnt_d;
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  // Next value of the saturating frame counters, stepped by the outcome pulses.
  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (frame_ok_q && (ok_cnt_q != 16'hFFFF)) begin
      ok_cnt_d = ok_cnt_q + 16'd1;
    end else begin
      ok_cnt_d = ok_cnt_q;
    end
    if (frame_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Frame counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ok_cnt_q  <= 16'h0000;
      err_cnt_q <= 16'h0000;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ok_cnt_o  = ok_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed testbench for rx_frame_parser (MAX_LEN=16, TIMEOUT_CYC=50).
`timescale 1ns/1ps

module tb_rx_frame_parser;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  cmd_o;
  logic [7:0]  len_o;
  logic [7:0]  pl_data_o;
  logic        pl_valid_o;
  logic [7:0]  pl_idx_o;
  logic        frame_ok_o;
  logic        frame_err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;
`ifdef RX_FRAME_STATS_EN
  logic [15:0] ok_cnt_o;
  logic [15:0] err_cnt_o;
`endif

  rx_frame_parser #(
    .SYNC_BYTE  (8'hA5),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(50),
    .TO_W       (17)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .cmd_o      (cmd_o),
    .len_o      (len_o),
    .pl_data_o  (pl_data_o),
    .pl_valid_o (pl_valid_o),
    .pl_idx_o   (pl_idx_o),
    .frame_ok_o (frame_ok_o),
    .frame_err_o(frame_err_o),
    .err_code_o (err_code_o),
`ifdef RX_FRAME_STATS_EN
    .ok_cnt_o   (ok_cnt_o),
    .err_cnt_o  (err_cnt_o),
`endif
    .busy_o     (busy_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Pulse log filled by the monitor.
  int         pl_n   = 0;
  int         ok_n   = 0;
  int         err_n  = 0;
  int         both_n = 0;
  logic [7:0] pl_d [0:63];
  logic [7:0] pl_i [0:63];

  int pl_b;
  int ok_b;
  int err_b;
  int n;

  // 100 MHz clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Monitor: record every output pulse on the falling edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (pl_valid_o) begin
        pl_d[pl_n % 64] = pl_data_o;
        pl_i[pl_n % 64] = pl_idx_o;
        pl_n = pl_n + 1;
      end
      if (frame_ok_o)  ok_n  = ok_n + 1;
      if (frame_err_o) err_n = err_n + 1;
      if (frame_ok_o && frame_err_o) both_n = both_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One byte strobe; returns just after the falling edge following its
  // capture, where the byte's registered response is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    #1;
  endtask

  task automatic snap();
    pl_b  = pl_n;
    ok_b  = ok_n;
    err_b = err_n;
  endtask

  initial begin
    rst_i      = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    #22;
    // Reset state.
    check("rst_cmd",   32'(cmd_o),       32'h0);
    check("rst_len",   32'(len_o),       32'h0);
    check("rst_pld",   32'(pl_data_o),   32'h0);
    check("rst_pli",   32'(pl_idx_o),    32'h0);
    check("rst_code",  32'(err_code_o),  32'h0);
    check("rst_busy",  32'(busy_o),      32'h0);
    check("rst_plv",   32'(pl_valid_o),  32'h0);
    check("rst_ok",    32'(frame_ok_o),  32'h0);
    check("rst_err",   32'(frame_err_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Good frame, CHK = 10^03^11^22^33 = 13.
    snap();
    send_byte(8'hA5);
    check("good_busy_hi", 32'(busy_o), 32'h1);
    send_byte(8'h10);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h13);
    check("good_ok_now", 32'(frame_ok_o), 32'h1);
    check("good_busy_lo", 32'(busy_o), 32'h0);
    check("good_cmd", 32'(cmd_o), 32'h10);
    check("good_len", 32'(len_o), 32'h03);
    check("good_npl", 32'(pl_n - pl_b), 32'd3);
    check("good_d0", 32'(pl_d[pl_b % 64]), 32'h11);
    check("good_d1", 32'(pl_d[(pl_b + 1) % 64]), 32'h22);
    check("good_d2", 32'(pl_d[(pl_b + 2) % 64]), 32'h33);
    check("good_i0", 32'(pl_i[pl_b % 64]), 32'h0);
    check("good_i1", 32'(pl_i[(pl_b + 1) % 64]), 32'h1);
    check("good_i2", 32'(pl_i[(pl_b + 2) % 64]), 32'h2);
    @(negedge clk_i); #1;
    check("good_nok", 32'(ok_n - ok_b), 32'd1);
    check("good_nerr", 32'(err_n - err_b), 32'd0);

    // Zero-length frame.
    snap();
    send_byte(8'hA5);
    send_byte(8'h42);
    send_byte(8'h00);
    send_byte(8'h42);
    check("zl_ok_now", 32'(frame_ok_o), 32'h1);
    check("zl_len", 32'(len_o), 32'h0);
    check("zl_cmd", 32'(cmd_o), 32'h42);
    check("zl_npl", 32'(pl_n - pl_b), 32'd0);

    // Checksum error: expected CHK is 10^01^FF = EE, 00 sent.
    snap();
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h00);
    check("ce_err_now", 32'(frame_err_o), 32'h1);
    check("ce_ok_now", 32'(frame_ok_o), 32'h0);
    check("ce_code", 32'(err_code_o), 32'h1);
    check("ce_npl", 32'(pl_n - pl_b), 32'd1);
    check("ce_d0", 32'(pl_d[pl_b % 64]), 32'hFF);
    check("ce_i0", 32'(pl_i[pl_b % 64]), 32'h0);
    check("ce_nok", 32'(ok_n - ok_b), 32'd0);

    // Length error: 0x11 > 16, then trailing bytes are ignored.
    snap();
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h11);
    check("le_err_now", 32'(frame_err_o), 32'h1);
    check("le_code", 32'(err_code_o), 32'h2);
    check("le_busy", 32'(busy_o), 32'h0);
    send_byte(8'h22);
    send_byte(8'h33);
    check("le_busy_after", 32'(busy_o), 32'h0);
    check("le_nerr", 32'(err_n - err_b), 32'd1);
    check("le_npl", 32'(pl_n - pl_b), 32'd0);

    // Timeout: error visible 50 cycles after the CMD byte is captured.
    snap();
    send_byte(8'hA5);
    send_byte(8'h10);
    n = 0;
    while (!frame_err_o && n < 60) begin
      @(negedge clk_i); #1;
      n = n + 1;
    end
    check("to_cycles", 32'(n), 32'd50);
    check("to_code", 32'(err_code_o), 32'h3);
    check("to_busy", 32'(busy_o), 32'h0);
    check("to_nerr", 32'(err_n - err_b), 32'd1);

    // Byte captured exactly in the expiry cycle is accepted instead.
    snap();
    send_byte(8'hA5);
    send_byte(8'h10);
    repeat (48) @(negedge clk_i);
    send_byte(8'h00);
    check("tb_busy", 32'(busy_o), 32'h1);
    check("tb_len", 32'(len_o), 32'h0);
    check("tb_nerr", 32'(err_n - err_b), 32'd0);
    send_byte(8'h10);
    check("tb_ok_now", 32'(frame_ok_o), 32'h1);
    check("tb_nerr2", 32'(err_n - err_b), 32'd0);

    // Noise in IDLE is dropped; last error cause is held.
    snap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("nz_busy", 32'(busy_o), 32'h0);
    check("nz_npl", 32'(pl_n - pl_b), 32'd0);
    check("nz_nok", 32'(ok_n - ok_b), 32'd0);
    check("nz_nerr", 32'(err_n - err_b), 32'd0);
    check("nz_code_hold", 32'(err_code_o), 32'h3);

    // Reset in the middle of the payload.
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h02);
    send_byte(8'h77);
    check("mr_pld_pre", 32'(pl_data_o), 32'h77);
    #2;
    rst_i = 1'b1;
    #1;
    check("mr_cmd",  32'(cmd_o),      32'h0);
    check("mr_len",  32'(len_o),      32'h0);
    check("mr_pld",  32'(pl_data_o),  32'h0);
    check("mr_pli",  32'(pl_idx_o),   32'h0);
    check("mr_code", 32'(err_code_o), 32'h0);
    check("mr_busy", 32'(busy_o),     32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Good frame after reset, CHK = 01^02^0A^0B = 02.
    snap();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h02);
    check("pr_ok_now", 32'(frame_ok_o), 32'h1);
    check("pr_npl", 32'(pl_n - pl_b), 32'd2);
    check("pr_d1", 32'(pl_d[(pl_b + 1) % 64]), 32'h0B);
    check("pr_i1", 32'(pl_i[(pl_b + 1) % 64]), 32'h1);
    check("pr_nerr", 32'(err_n - err_b), 32'd0);
    @(negedge clk_i); #1;
`ifdef RX_FRAME_STATS_EN
    check("st_ok",  32'(ok_cnt_o),  32'd1);
    check("st_err", 32'(err_cnt_o), 32'd0);
`endif
    check("never_both", 32'(both_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_frame_parser.md
Name: rx_frame_parser

Overview:
- Byte-level frame parser directly downstream of the RS-232 receive path.
- Consumes each received byte, presented as parallel data plus a one-cycle strobe at end-of-reception, and recognises frames of the form SYNC, CMD, LEN, payload[LEN], CHK.
- Streams payload bytes to the consumer.
- Reports frame completion or error with one-cycle pulses.
- Sits between the UART receiver and the command/register logic.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum legal payload length in bytes (1..255).
- TIMEOUT_CYC, 100000, inter-byte timeout in clk_i cycles while a frame is open (≥2).
- TO_W, 17, width of the timeout counter (must hold TIMEOUT_CYC-1).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- rx_data_i  in  8  received byte; valid only when rx_valid_i=1
- rx_valid_i  in  1  one-cycle strobe, one per received byte
- cmd_o  out  8  CMD byte of current/last frame
- len_o  out  8  LEN byte of current/last frame
- pl_data_o  out  8  payload byte
- pl_valid_o  out  1  one-cycle strobe qualifying pl_data_o
- pl_idx_o  out  8  index of the payload byte (0..LEN-1)
- frame_ok_o  out  1  one-cycle pulse: checksum matched
- frame_err_o  out  1  one-cycle pulse: frame aborted
- err_code_o  out  2  last error cause; 1=checksum, 2=length, 3=timeout
- busy_o  out  1  high while state != IDLE

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - All outputs 0: cmd_o, len_o, pl_data_o, pl_idx_o, err_code_o = 0; strobes and busy_o = 0.
  - Checksum accumulator, payload counter and timeout counter = 0.
  - Reset mid-frame discards the frame with no pulse.
- General:
  - All outputs are registered.
  - Response to a byte sampled with rx_valid_i=1 at edge N appears after edge N (visible cycle N+1).
  - Pulses last exactly one cycle.
- Checksum: chk = XOR of CMD, LEN and all payload bytes (8-bit). SYNC is excluded.
- States, all transitions on rx_valid_i=1 unless noted:
  - IDLE:
    - byte==SYNC_BYTE -> CMD; clear chk, payload counter, timeout counter.
    - Any other byte is dropped silently (no error).
  - CMD: cmd_o<=byte; chk<=byte; -> LEN.
  - LEN: len_o<=byte; chk^=byte.
    - byte>MAX_LEN -> IDLE, frame_err_o, err_code_o=2.
    - byte==0 -> CHK.
    - else -> DATA.
  - DATA: pl_data_o<=byte, pl_idx_o<=counter, pl_valid_o pulse; chk^=byte; counter++.
    - When counter==len_o-1 (last byte) -> CHK.
  - CHK:
    - byte==chk -> frame_ok_o pulse.
    - else -> frame_err_o, err_code_o=1.
    - -> IDLE in both cases.
- Timeout:
  - In any state other than IDLE, the counter increments on each cycle with rx_valid_i=0 and clears on rx_valid_i=1.
  - When counter==TIMEOUT_CYC-1 and rx_valid_i=0 -> IDLE, frame_err_o, err_code_o=3.
  - rx_valid_i in the expiry cycle wins: the byte is processed and there is no timeout.
- A SYNC_BYTE value received in CMD/LEN/DATA/CHK is treated as ordinary data; there is no resync.
- cmd_o, len_o and err_code_o hold their values until overwritten.
- frame_ok_o and frame_err_o are never asserted in the same cycle.
- busy_o = (state != IDLE), registered with the state.

Optional Feature:
- Macro: RX_FRAME_STATS_EN.
- Defined:
  - Adds output ports ok_cnt_o[15:0] and err_cnt_o[15:0].
  - Each counter increments on its frame_ok_o / frame_err_o pulse and saturates at 16'hFFFF.
  - Both are cleared by rst_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Good frame: bytes A5,10,03,11,22,33,CHK=10^03^11^22^33=0x13 -> 3 pl_valid_o pulses with data 11/22/33 and idx 0/1/2; cmd_o=10, len_o=03; one frame_ok_o; busy_o back to 0.
- Zero length: A5,42,00,42 -> frame_ok_o; no pl_valid_o.
- Checksum error: A5,10,01,FF,00 -> pl_valid_o once (FF); frame_err_o with err_code_o=1.
- Length error with MAX_LEN=16: A5,10,11 -> frame_err_o immediately after the LEN byte, err_code_o=2; following bytes are ignored until the next A5.
- Timeout with TIMEOUT_CYC=50: A5,10 then silence -> frame_err_o exactly 50 idle cycles after the CMD strobe, err_code_o=3; a byte arriving in the 50th cycle instead is accepted with no error.
- Noise and reset: 00,FF,5A while IDLE -> no outputs; rst_i asserted mid-DATA -> all outputs 0 and state IDLE, then a subsequent good frame passes. With RX_FRAME_STATS_EN, the counters read ok=1, err=0.
